blake_round_ctrl: RTL and testbench
===================================

// Module: blake_round_ctrl
// PURPOSE
//  Sequencer for the BLAKE-512 compression datapath and blake_finalize. Accepts message blocks
//  via valid/ready, loads v, steps 16 rounds (column then diagonal half-round), and drives
//  init_round / count_done / rdy_from_counter into blake_finalize. Maintains the 128-bit bit
//  counter t per BLAKE-512 padding rules. One message in flight; blocks processed back-to-back.
// PARAMETERS
//  ROUNDS      16   rounds per compression; round_idx wraps sigma index externally (mod 10)
//  CYC_PER_RND 2    cycles per round: step=0 column G's, step=1 diagonal G's
//  T_W         128  bit-counter width
// PORTS
//  clk              in   1    clock, all logic rising-edge
//  rstb             in   1    reset; synchronous, active-high (1 = reset), despite the name
//  blk_valid        in   1    message block (m, blk_bits, blk_last) present
//  blk_ready        out  1    controller accepts block this cycle
//  blk_last         in   1    block is final block of message
//  blk_bits         in   11   message bits in block, 0..1024 (0 = padding-only block)
//  init_round       out  1    1-cycle pulse: load IV into h (first block of message)
//  v_init           out  1    1-cycle pulse: load v from h, salt, constants, t
//  round_idx        out  4    current round 0..ROUNDS-1
//  step             out  1    0 = column half, 1 = diagonal half
//  count_done       out  1    1-cycle pulse: v_state_next final for block; h and stage1 capture
//  rdy_from_counter out  1    1-cycle pulse: last block done; finalize output register loads
//  t_ctr            out  T_W  counter presented to v_init (zero when t_null)
//  t_null           out  1    current block is padding-only; counter treated as 0
//  busy             out  1    state != IDLE
//  err              out  1    sticky: blk_bits > 1024 accepted; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, t=0, round_idx=0, step=0, err=0; all pulses 0, blk_ready=0 in reset cycle.
//  States: IDLE, LOAD, ROUND, WAIT_BLK, FIN.
//  IDLE: blk_ready=1. On accept (valid&ready): init_round=1 same cycle, t<=blk_bits, -> LOAD.
//  WAIT_BLK: blk_ready=1, no init_round. On accept: t<=t+blk_bits (mod 2^T_W) -> LOAD.
//  blk_bits>1024: clamp to 1024 for t, set err; block still processed.
//  t_null<=(blk_bits==0) at accept; t_ctr = t_null ? 0 : t; both held stable LOAD..count_done.
//  blk_last captured at accept; held until block completes.
//  LOAD: v_init=1 one cycle, round_idx=0, step=0 -> ROUND.
//  ROUND: step toggles each cycle; round_idx increments when step goes 1->0.
//    Exactly ROUNDS*CYC_PER_RND cycles. On last cycle (round_idx=ROUNDS-1, step=1): count_done=1;
//    then -> FIN if blk_last, else -> WAIT_BLK.
//  FIN: rdy_from_counter=1 one cycle -> IDLE (t cleared to 0).
//  Latency, single block accepted cycle A: v_init A+1, rounds A+2..A+33, count_done A+33,
//    rdy_from_counter A+34, blake_finalize.rdy A+35; blk_ready again at A+35 (IDLE).
//  Multi-block: next accept earliest the cycle after count_done (WAIT_BLK); count_done per block.
//  blk_ready=0 in LOAD/ROUND/FIN; blk_valid there ignored, no state change.
//  Never assert count_done and rdy_from_counter same cycle; never init_round outside IDLE accept.
//  rstb asserted mid-block: next cycle IDLE, t=0, no count_done/rdy_from_counter emitted.
// STRUCTURE
//  blake_pkg: ROUNDS default, BLOCK_BITS=1024, state enum (IDLE/LOAD/ROUND/WAIT_BLK/FIN).
//  Sub-module blake_t_counter: T_W accumulator with clear, add-clamped-bits, null flag.
//  FSM + round/step counters inline; all outputs registered or decoded from state only.
// TESTING
//  1 block, blk_bits=1024, last=1 -> init_round@A, v_init@A+1, count_done@A+33, rdy_f_c@A+34, t=1024.
//  3 blocks 1024/1024/512 back-to-back -> 3 count_done, t=1024,2048,2560, one init_round, one rdy_f_c.
//  Padding block blk_bits=0 last=1 after 1024 -> t_null=1, t_ctr=0, t stays 1024.
//  t preset 2^128-512, add 1024 -> t_ctr wraps to 512; blk_bits=1500 -> err=1, t+=1024.
//  blk_valid held through ROUND -> blk_ready=0, no accept; rstb at round 7 -> IDLE, no pulses.
//  round_idx/step trace -> 0/0,0/1,1/0..15/1, exactly 32 ROUND cycles per block.

Source files
------------

// File: rtl/blake_round_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the BLAKE-512 round sequencer.
package blake_round_ctrl_pkg;

  localparam int DEF_ROUNDS  = 16;
  localparam int DEF_T_W     = 128;
  localparam int BLOCK_BITS  = 1024;
  localparam int BITS_W      = 11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ROUND    = 3'd2,
    WAIT_BLK = 3'd3,
    FIN      = 3'd4
  } state_e;

  // A block never contributes more than one full block of bits to the counter.
  function automatic logic [BITS_W-1:0] clamp_bits(input logic [BITS_W-1:0] bits);
    return (bits > BITS_W'(BLOCK_BITS)) ? BITS_W'(BLOCK_BITS) : bits;
  endfunction

endpackage

// File: rtl/blake_round_ctrl_if.sv
// Message-block handshake between the block source and the round sequencer.
interface blake_round_ctrl_if;
  import blake_round_ctrl_pkg::*;

  logic              blk_valid;
  logic              blk_ready;
  logic              blk_last;
  logic [BITS_W-1:0] blk_bits;

  modport master (
    output blk_valid,
    output blk_last,
    output blk_bits,
    input  blk_ready
  );

  modport slave (
    input  blk_valid,
    input  blk_last,
    input  blk_bits,
    output blk_ready
  );

endinterface

// File: rtl/blake_round_ctrl_t_counter.sv
// BLAKE-512 bit counter t: loads on the first block, accumulates clamped block sizes,
// flags padding-only blocks, and records oversized blocks in a sticky error bit.
module blake_round_ctrl_t_counter
  import blake_round_ctrl_pkg::*;
#(
  parameter int T_W = DEF_T_W
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              clr,
  input  logic              start,
  input  logic              accum,
  input  logic [BITS_W-1:0] bits,
  output logic [T_W-1:0]    t_ctr,
  output logic              t_null,
  output logic              err
);

  logic [T_W-1:0]    t_q;
  logic [BITS_W-1:0] bits_c;
  logic [T_W-1:0]    bits_ext;

  assign bits_c   = clamp_bits(bits);
  assign bits_ext = T_W'(bits_c);

  // Counter, null flag and sticky error update on each accepted block; cleared after the message.
  always_ff @(posedge clk) begin
    if (rstb) begin
      t_q    <= '0;
      t_null <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (clr) begin
        t_q    <= '0;
        t_null <= 1'b0;
      end else if (start) begin
        t_q <= bits_ext;
      end else if (accum) begin
        t_q <= t_q + bits_ext;
      end
      if (start || accum) begin
        t_null <= (bits == '0);
        if (bits > BITS_W'(BLOCK_BITS)) err <= 1'b1;
      end
    end
  end

  // A padding-only block is compressed with a zero counter, while t itself keeps its value.
  assign t_ctr = t_null ? '0 : t_q;

endmodule

// File: rtl/blake_round_ctrl.sv
// Round sequencer for the BLAKE-512 compression datapath and its finalize stage.
//
//  state    | meaning
//  IDLE     | no message in flight, ready for the first block
//  LOAD     | v loaded from h, salt, constants and t (v_init)
//  ROUND    | column/diagonal half-rounds, two cycles per round
//  WAIT_BLK | block done, message not finished, ready for next block
//  FIN      | last block done, finalize output register loads
module blake_round_ctrl
  import blake_round_ctrl_pkg::*;
#(
  parameter int ROUNDS = DEF_ROUNDS,
  parameter int T_W    = DEF_T_W
) (
  input  logic                  clk,
  input  logic                  rstb,
  blake_round_ctrl_if.slave     blk,
  output logic                  init_round,
  output logic                  v_init,
  output logic [3:0]            round_idx,
  output logic                  step,
  output logic                  count_done,
  output logic                  rdy_from_counter,
  output logic [T_W-1:0]        t_ctr,
  output logic                  t_null,
  output logic                  busy,
  output logic                  err
);

  state_e     state;
  logic [3:0] round_q;
  logic       step_q;
  logic       last_q;
  logic       can_accept;
  logic       accept;
  logic       last_cyc;

  assign can_accept    = (state == IDLE) || (state == WAIT_BLK);
  assign blk.blk_ready = can_accept && !rstb;
  assign accept        = blk.blk_valid && blk.blk_ready;
  assign last_cyc      = (state == ROUND) && (round_q == 4'(ROUNDS - 1)) && step_q;

  // Sequencer state plus round/step counters; blk_last is latched at accept for the whole block.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state   <= IDLE;
      round_q <= '0;
      step_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT_BLK: begin
          if (accept) begin
            last_q <= blk.blk_last;
            state  <= LOAD;
          end
        end
        LOAD: begin
          round_q <= '0;
          step_q  <= 1'b0;
          state   <= ROUND;
        end
        ROUND: begin
          step_q <= ~step_q;
          if (last_cyc) begin
            round_q <= '0;
            state   <= last_q ? FIN : WAIT_BLK;
          end else if (step_q) begin
            round_q <= round_q + 4'd1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pulses are decoded from registered state and suppressed during a reset cycle.
  assign init_round       = accept && (state == IDLE);
  assign v_init           = (state == LOAD) && !rstb;
  assign count_done       = last_cyc && !rstb;
  assign rdy_from_counter = (state == FIN) && !rstb;
  assign busy             = (state != IDLE);
  assign round_idx        = round_q;
  assign step             = step_q;

  blake_round_ctrl_t_counter #(.T_W(T_W)) u_t_counter (
    .clk    (clk),
    .rstb   (rstb),
    .clr    (state == FIN),
    .start  (accept && (state == IDLE)),
    .accum  (accept && (state == WAIT_BLK)),
    .bits   (blk.blk_bits),
    .t_ctr  (t_ctr),
    .t_null (t_null),
    .err    (err)
  );

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Self-checking bench for blake_round_ctrl: vector table, hand-written reset and wrap
// sequences, and randomized messages checked against a running-sum model of t.
module tb_blake_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb;

  blake_round_ctrl_if u_if ();
  blake_round_ctrl_if u_if2 ();

  logic         init_round, v_init, step, count_done, rdy_fc, t_null, busy, err;
  logic [3:0]   round_idx;
  logic [127:0] t_ctr;

  logic         init_round2, v_init2, step2, count_done2, rdy_fc2, t_null2, busy2, err2;
  logic [3:0]   round_idx2;
  logic [11:0]  t_ctr2;

  blake_round_ctrl dut (
    .clk(clk), .rstb(rstb), .blk(u_if),
    .init_round(init_round), .v_init(v_init), .round_idx(round_idx), .step(step),
    .count_done(count_done), .rdy_from_counter(rdy_fc), .t_ctr(t_ctr), .t_null(t_null),
    .busy(busy), .err(err)
  );

  blake_round_ctrl #(.T_W(12)) dut2 (
    .clk(clk), .rstb(rstb), .blk(u_if2),
    .init_round(init_round2), .v_init(v_init2), .round_idx(round_idx2), .step(step2),
    .count_done(count_done2), .rdy_from_counter(rdy_fc2), .t_ctr(t_ctr2), .t_null(t_null2),
    .busy(busy2), .err(err2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block: optional idle gap, accept, then the full LOAD/ROUND(/FIN/IDLE) window.
  task automatic run_block(input logic [10:0] bits, input bit last, input bit first,
                           input int gap, input bit hold, input logic [127:0] exp_t,
                           input bit exp_null, input bit exp_err);
    int lim;
    int hold_lim;
    for (int g = 0; g < gap; g++) begin
      tick();
      u_if.blk_valid = 1'b0;
      #1;
      chk("ready_while_waiting", u_if.blk_ready, 1);
      chk("busy_while_waiting", busy, !first);
    end
    tick();
    u_if.blk_valid = 1'b1;
    u_if.blk_bits  = bits;
    u_if.blk_last  = last;
    #1;
    chk("accept_ready", u_if.blk_ready, 1);
    chk("init_round_at_accept", init_round, first);
    lim      = last ? 35 : 33;
    hold_lim = last ? 34 : 33;
    for (int k = 1; k <= lim; k++) begin
      tick();
      if (hold && k <= hold_lim) begin
        u_if.blk_valid = 1'b1;
        u_if.blk_bits  = 11'($urandom);
        u_if.blk_last  = 1'($urandom);
      end else begin
        u_if.blk_valid = 1'b0;
      end
      #1;
      chk("blk_ready", u_if.blk_ready, (k == 35));
      chk("init_round_quiet", init_round, 0);
      chk("v_init", v_init, (k == 1));
      chk("count_done", count_done, (k == 33));
      chk("rdy_from_counter", rdy_fc, (k == 34));
      chk("busy", busy, (k <= 34));
      chk("err", err, exp_err);
      if (k >= 2 && k <= 33) begin
        chk("round_idx", round_idx, (k - 2) / 2);
        chk("step", step, (k - 2) % 2);
      end
      if (k <= 33) begin
        chk("t_ctr", t_ctr, exp_t);
        chk("t_null", t_null, exp_null);
      end
      if (k == 35) chk("t_ctr_cleared", t_ctr, 0);
    end
  endtask

  // Small-counter instance: accept a block and follow it to count_done (and FIN if last).
  task automatic send2(input logic [10:0] bits, input bit last, input logic [11:0] exp_t);
    int w;
    tick();
    u_if2.blk_valid = 1'b1;
    u_if2.blk_bits  = bits;
    u_if2.blk_last  = last;
    #1;
    w = 0;
    while (!u_if2.blk_ready && w < 50) begin
      tick();
      w++;
    end
    chk("dut2_ready", u_if2.blk_ready, 1);
    tick();
    u_if2.blk_valid = 1'b0;
    #1;
    chk("dut2_v_init", v_init2, 1);
    chk("dut2_t_ctr", t_ctr2, exp_t);
    w = 0;
    while (!count_done2 && w < 60) begin
      tick();
      w++;
    end
    chk("dut2_count_done", count_done2, 1);
    if (last) begin
      tick();
      chk("dut2_rdy_from_counter", rdy_fc2, 1);
    end
  endtask

  typedef struct {
    logic [10:0]  bits;
    bit           last;
    bit           hold;
    logic [127:0] exp_t;
    bit           exp_null;
    bit           exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [127:0] t_ref;
    bit           err_ref;
    bit           in_msg;
    int           pulses;

    tbl[0] = '{bits: 11'd1024, last: 1'b1, hold: 1'b0, exp_t: 128'd1024, exp_null: 1'b0, exp_err: 1'b0};
    tbl[1] = '{bits: 11'd1024, last: 1'b0, hold: 1'b1, exp_t: 128'd1024, exp_null: 1'b0, exp_err: 1'b0};
    tbl[2] = '{bits: 11'd1024, last: 1'b0, hold: 1'b0, exp_t: 128'd2048, exp_null: 1'b0, exp_err: 1'b0};
    tbl[3] = '{bits: 11'd512,  last: 1'b1, hold: 1'b1, exp_t: 128'd2560, exp_null: 1'b0, exp_err: 1'b0};
    tbl[4] = '{bits: 11'd1024, last: 1'b0, hold: 1'b0, exp_t: 128'd1024, exp_null: 1'b0, exp_err: 1'b0};
    tbl[5] = '{bits: 11'd0,    last: 1'b1, hold: 1'b0, exp_t: 128'd0,    exp_null: 1'b1, exp_err: 1'b0};
    tbl[6] = '{bits: 11'd1500, last: 1'b0, hold: 1'b0, exp_t: 128'd1024, exp_null: 1'b0, exp_err: 1'b1};
    tbl[7] = '{bits: 11'd1024, last: 1'b1, hold: 1'b1, exp_t: 128'd2048, exp_null: 1'b0, exp_err: 1'b1};

    rstb            = 1'b1;
    u_if.blk_valid  = 1'b1;
    u_if.blk_bits   = 11'd1024;
    u_if.blk_last   = 1'b1;
    u_if2.blk_valid = 1'b0;
    u_if2.blk_bits  = 11'd0;
    u_if2.blk_last  = 1'b0;

    // Reset: handshake and pulses held low even with valid asserted.
    repeat (3) tick();
    chk("rst_blk_ready", u_if.blk_ready, 0);
    chk("rst_init_round", init_round, 0);
    chk("rst_v_init", v_init, 0);
    tick();
    rstb           = 1'b0;
    u_if.blk_valid = 1'b0;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_round_idx", round_idx, 0);
    chk("post_rst_step", step, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_t_ctr", t_ctr, 0);
    chk("post_rst_t_null", t_null, 0);
    chk("post_rst_ready", u_if.blk_ready, 1);
    chk("post_rst_count_done", count_done, 0);
    chk("post_rst_rdy", rdy_fc, 0);

    // Vector table.
    in_msg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_block(tbl[i].bits, tbl[i].last, !in_msg, i % 3, tbl[i].hold,
                tbl[i].exp_t, tbl[i].exp_null, tbl[i].exp_err);
      in_msg = !tbl[i].last;
    end

    // Reset at round 7 of a block: back to IDLE with no completion pulses.
    tick();
    u_if.blk_valid = 1'b1;
    u_if.blk_bits  = 11'd1024;
    u_if.blk_last  = 1'b1;
    #1;
    chk("mid_init_round", init_round, 1);
    for (int k = 1; k <= 16; k++) tick();
    chk("mid_round_idx", round_idx, 7);
    chk("mid_step", step, 0);
    chk("mid_ready_held_valid", u_if.blk_ready, 0);
    tick();
    rstb = 1'b1;
    #1;
    chk("mid_rst_count_done", count_done, 0);
    chk("mid_rst_rdy", rdy_fc, 0);
    chk("mid_rst_ready", u_if.blk_ready, 0);
    tick();
    rstb           = 1'b0;
    u_if.blk_valid = 1'b0;
    #1;
    chk("mid_post_busy", busy, 0);
    chk("mid_post_t_ctr", t_ctr, 0);
    chk("mid_post_round_idx", round_idx, 0);
    chk("mid_post_err", err, 0);
    chk("mid_post_ready", u_if.blk_ready, 1);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (count_done || rdy_fc || v_init || init_round) pulses++;
    end
    chk("mid_no_pulses", pulses, 0);

    // Random messages against a running-sum model of t.
    t_ref   = '0;
    err_ref = 1'b0;
    in_msg  = 1'b0;
    for (int r = 0; r < 14; r++) begin
      logic [10:0] bits;
      bit          last;
      int          sel;
      int          clamp;
      sel = $urandom_range(0, 9);
      if (sel == 0)      bits = 11'd0;
      else if (sel == 1) bits = 11'($urandom_range(1025, 2047));
      else if (sel == 2) bits = 11'd1024;
      else               bits = 11'($urandom_range(1, 1024));
      last  = ($urandom_range(0, 2) == 0) || (r == 13);
      clamp = (bits > 11'd1024) ? 1024 : int'(bits);
      t_ref = in_msg ? t_ref + 128'(clamp) : 128'(clamp);
      if (bits > 11'd1024) err_ref = 1'b1;
      run_block(bits, last, !in_msg, $urandom_range(0, 3), 1'($urandom),
                (bits == 11'd0) ? 128'd0 : t_ref, (bits == 11'd0), err_ref);
      in_msg = !last;
    end

    // 12-bit counter wrap: 3*1024 + 512 = 3584 = 2^12 - 512, then +1024 wraps to 512.
    send2(11'd1024, 1'b0, 12'd1024);
    send2(11'd1024, 1'b0, 12'd2048);
    send2(11'd1024, 1'b0, 12'd3072);
    send2(11'd512,  1'b0, 12'd3584);
    send2(11'd1024, 1'b1, 12'd512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
